// File: rtl/gate_sweep_checker.sv
// Drives every input vector onto a gate, waits SETTLE cycles, checks the output against AND/OR.
// Optional build macro GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// WAIT   | vector driven, settle counter running down
// CHECK  | compare gate output, advance or finish
// FINISH | one-cycle done pulse
module gate_sweep_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            func,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, FINISH} state_t;

  state_t            state, state_nxt;
  logic [N_IN-1:0]   vec;
  logic [CNT_W-1:0]  cnt;
  logic              fail_seen;
  logic              func_q;
  logic              expected;
  logic              mismatch;
  logic              last_vec;

  assign dut_in = vec;

  always_comb begin
    expected = func_q ? (|vec) : (&vec);
    mismatch = (dut_out != expected);
    last_vec = &vec;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        state_nxt = (last_vec || mismatch) ? FINISH : WAIT;
`else
        state_nxt = last_vec ? FINISH : WAIT;
`endif
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      fail_seen  <= 1'b0;
      func_q     <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            vec        <= '0;
            cnt        <= CNT_RELOAD;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            pass       <= 1'b0;
            func_q     <= func;
          end
        end
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!fail_seen) begin
              first_fail <= vec;
              fail_seen  <= 1'b1;
            end
          end
          // pass is settled on the way into FINISH so it is already valid during the done pulse
          if (state_nxt == FINISH) begin
            pass <= !mismatch && (err_count == '0);
          end else begin
            vec <= vec + 1'b1;
            cnt <= CNT_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker with a behavioural gate model selectable per step.
// Expectations follow GATE_SWEEP_STOP_ON_FAIL_EN when the bench is built with it defined.
module tb_gate_sweep_checker;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       func;
  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;

  int gate_mode;  // 0 AND gate, 1 OR gate, 2 output tied low
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (gate_mode)
      0:       dut_out = &dut_in;
      1:       dut_out = |dut_in;
      default: dut_out = 1'b0;
    endcase
  end

  gate_sweep_checker #(.N_IN(3), .SETTLE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .func       (func),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next edge k, and n counts negedges after k.
  task automatic run_sweep(input int mode, input logic f, input bit repulse, input bit start_in_done,
                           input bit trace, output int done_n, output int busy_n,
                           output int done_cnt, output int trace_err);
    done_n = 0; busy_n = 0; done_cnt = 0; trace_err = 0;
    gate_mode = mode;
    func  = f;
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 3) func = ~f;
      if (repulse && n == 4) start = 1'b1;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
        if (start_in_done) start = 1'b1;
      end
      if (trace && n <= 40 && dut_in !== 3'((n - 1) / 5)) trace_err++;
    end
    start = 1'b0;
  endtask

  int dn, bn, dc, te;

  initial begin
    rst = 1'b1; start = 1'b0; func = 1'b0; gate_mode = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_fail, 0);
    chk("rst_dut_in", dut_in, 0);
    rst = 1'b0;
    @(negedge clk);

    // correct AND gate
    run_sweep(0, 1'b0, 0, 0, 1, dn, bn, dc, te);
    chk("and_done_cycle", dn, 41);
    chk("and_busy_cycles", bn, 40);
    chk("and_done_pulses", dc, 1);
    chk("and_vec_trace", te, 0);
    chk("and_pass", pass, 1);
    chk("and_err", err_count, 0);
    chk("and_first", first_fail, 0);
    chk("and_dut_in_hold", dut_in, 7);

    // OR gate checked as AND
    run_sweep(1, 1'b0, 0, 0, 0, dn, bn, dc, te);
    chk("or_done_cycle", dn, STOP ? 11 : 41);
    chk("or_err", err_count, STOP ? 1 : 6);
    chk("or_first", first_fail, 1);
    chk("or_pass", pass, 0);
    chk("or_dut_in", dut_in, STOP ? 1 : 7);
    chk("or_done_pulses", dc, 1);

    // output tied low checked as OR
    run_sweep(2, 1'b1, 0, 0, 0, dn, bn, dc, te);
    chk("tie0_done_cycle", dn, STOP ? 11 : 41);
    chk("tie0_err", err_count, STOP ? 1 : 7);
    chk("tie0_first", first_fail, 1);
    chk("tie0_pass", pass, 0);

    // reset mid-sweep with a failing gate
    gate_mode = 1; func = 1'b0; start = 1'b1;
    dc = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dc++;
    end
    chk("mid_err_before_rst", err_count, STOP ? 1 : 2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dut_in", dut_in, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_first", first_fail, 0);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
    end
    chk("mid_done_pulses", dc, STOP ? 1 : 0);
    run_sweep(0, 1'b0, 0, 0, 1, dn, bn, dc, te);
    chk("post_rst_done_cycle", dn, 41);
    chk("post_rst_busy_cycles", bn, 40);
    chk("post_rst_pass", pass, 1);

    // start re-pulsed mid-sweep and in the done cycle
    run_sweep(0, 1'b0, 1, 1, 1, dn, bn, dc, te);
    chk("repulse_done_cycle", dn, 41);
    chk("repulse_done_pulses", dc, 1);
    chk("repulse_busy_cycles", bn, 40);
    chk("repulse_vec_trace", te, 0);
    chk("repulse_pass", pass, 1);
    chk("repulse_err", err_count, 0);
    chk("repulse_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking stimulus/response stage for the combinational gate library. It sits directly around a 3-input gate instance: it drives every input vector onto the gate, waits a programmable settle time, samples the gate output and compares it with the expected AND or OR result. It then reports the pass/fail status, the mismatch count and the first failing vector. It replaces hand-written delay sweeps in per-gate benches with one clocked, reusable block.

## Interface
- `N_IN`, default 3: gate input width, legal range 2..8; the sweep covers 2^N_IN vectors.
- `SETTLE`, default 4: clock cycles each vector is held before sampling; must be ≥1 and exceed the gate propagation delay.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `func`  in  1  expected function, latched at start: 0 = AND of all inputs, 1 = OR.
- `dut_in`  out  N_IN  registered vector driven to the gate inputs.
- `dut_out`  in  1  gate output; combinational, sampled in CHECK.
- `busy`  out  1  high in WAIT and CHECK.
- `done`  out  1  one-cycle pulse in FINISH.
- `pass`  out  1  1 when the last sweep had zero mismatches; valid from FINISH until the next start.
- `err_count`  out  N_IN+1  mismatches in the current or last sweep.
- `first_fail`  out  N_IN  vector of the first mismatch; 0 if none.

## Operation
- States: IDLE, WAIT, CHECK, FINISH.
- Reset values: state IDLE; `dut_in`, `busy`, `done`, `pass`, `err_count` and `first_fail` are all 0; the internal `vec`, `cnt` and `fail_seen` are 0.
- **IDLE.** `start` = 1 does the following:
  - sets `vec` ← 0, `cnt` ← SETTLE−1;
  - clears `err_count`, `first_fail`, `fail_seen` and `pass`;
  - latches `func`;
  - moves to WAIT.
- **WAIT.** `dut_in` = `vec`. While `cnt` ≠ 0, decrement it. When `cnt` = 0, move to CHECK.
- **CHECK** (one cycle):
  - expected = func ? |vec : &vec.
  - If `dut_out` ≠ expected: `err_count` += 1; if `fail_seen` = 0, capture `first_fail` ← `vec` and set `fail_seen`.
  - If `vec` = all-ones, go to FINISH. Otherwise `vec` += 1, reload `cnt`, return to WAIT.
- **FINISH:**
  - `done` = 1; `busy` = 0;
  - `pass` ← (`err_count` == 0), using the count already including the final CHECK;
  - next state is IDLE.
- After a sweep, `dut_in` holds the last driven vector until the next start or reset.
- `err_count` cannot overflow: the maximum is 2^N_IN, which fits in N_IN+1 bits.
- `start` while `busy` or in FINISH is ignored; there is no queuing.
- A change of `func` mid-sweep has no effect.
- `rst` mid-sweep returns everything to reset values on the next edge, aborting the sweep; no `done` is generated.

## Timing
- `start` sampled high at edge k gives: WAIT from cycle k+1; `dut_in` = 0 visible from k+1.
- Each vector takes SETTLE WAIT cycles plus 1 CHECK cycle = SETTLE+1 cycles.
- `done` is high in cycle k+1+2^N_IN·(SETTLE+1). With defaults: cycle k+41, i.e. 40 cycles of busy.
- `dut_in` changes only on a CHECK→WAIT transition.
- `dut_out` is sampled exactly SETTLE cycles after `dut_in` changes.
- `start` is accepted again in the cycle after `done`.

## Configuration
- Macro: `GATE_SWEEP_STOP_ON_FAIL_EN`.
- **Defined:** a CHECK with a mismatch goes straight to FINISH.
  - `err_count` = 1; `dut_in` holds the failing vector; `pass` = 0.
  - `done` arrives at cycle k+1+(first_fail+1)·(SETTLE+1).
- **Undefined:** the sweep always covers all 2^N_IN vectors.
- Ports and widths are identical in both builds.

## Test plan
- Correct 3-input AND gate, `func` = 0, `start` at edge k:
  - `busy` 40 cycles, `done` at k+41;
  - `pass` = 1, `err_count` = 0, `first_fail` = 0.
- OR gate connected, `func` = 0:
  - mismatches on vectors 1–6;
  - `err_count` = 6, `first_fail` = 3'b001, `pass` = 0.
- `dut_out` tied 0, `func` = 1:
  - `err_count` = 7, `first_fail` = 3'b001, `pass` = 0.
- Same OR-vs-AND mismatch with `GATE_SWEEP_STOP_ON_FAIL_EN` defined:
  - `done` at k+11;
  - `err_count` = 1, `dut_in` = 3'b001, `pass` = 0.
- `rst` asserted at cycle k+17, then released:
  - next cycle `busy` = 0, `dut_in` = 0, `err_count` = 0, no `done` pulse;
  - a fresh `start` completes a normal 40-cycle sweep.
- `start` re-pulsed at k+5 and in the `done` cycle:
  - both ignored; `done` occurs once at k+41 and results are unchanged.
